move_player_ctrl: RTL

//  Parametrised per-player movement controller for the platformer core (Jack Frost).

---
 rtl/move_player_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/move_player_ctrl.sv
// ----------------------------------------------------------------------------
// move_player_ctrl
//   Per-player movement controller. On every frame tick it advances one
//   character's position from the direction keys and the four-sided collision
//   flags. The vertical axis runs a GROUND/RISE/FALL machine with a signed
//   velocity (positive = upward), gravity, a fall-speed cap and variable jump
//   height: releasing the key cuts the jump. Both axes are clamped to the
//   screen.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset (wins over tick)
//   tick         one-clk frame strobe; state only changes on ticks
//   key_jump     jump key level
//   key_left     left key level
//   key_right    right key level
//   coll[3:0]    [0] ground below, [1] ceiling above, [2] wall right,
//                [3] wall left
//   x_pos        current x (pixels)
//   y_pos        current y (pixels, grows downward)
//   vy           current signed vertical velocity
//   mstate       0 GROUND, 1 RISE, 2 FALL
//   facing_left  1 = sprite faces left
//   moving       1 = x changed on the last tick
//
// The y arithmetic is done at Y_W+2 signed bits and assumes Y_W+2 > V_W.
// ----------------------------------------------------------------------------
module move_player_ctrl #(
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int V_W      = 9,
    parameter int H_SPEED  = 1,
    parameter int JUMP_V   = 14,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 14,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 623,
    parameter int Y_MAX    = 463,
    parameter int X_INIT   = 32,
    parameter int Y_INIT   = 400
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  key_jump,
    input  logic                  key_left,
    input  logic                  key_right,
    input  logic [3:0]            coll,
    output logic [X_W-1:0]        x_pos,
    output logic [Y_W-1:0]        y_pos,
    output logic signed [V_W-1:0] vy,
    output logic [1:0]            mstate,
    output logic                  facing_left,
    output logic                  moving
);

    localparam logic [1:0] ST_GROUND = 2'd0;
    localparam logic [1:0] ST_RISE   = 2'd1;
    localparam logic [1:0] ST_FALL   = 2'd2;

    localparam int YS_W = Y_W + 2;

    localparam logic [X_W:0]          H_EXT    = (X_W+1)'(H_SPEED);
    localparam logic [X_W:0]          XMIN_EXT = (X_W+1)'(X_MIN);
    localparam logic [X_W:0]          XMAX_EXT = (X_W+1)'(X_MAX);
    localparam logic signed [V_W:0]   GRAV_S   = (V_W+1)'(GRAVITY);
    localparam logic signed [V_W:0]   NEG_MAX  = (V_W+1)'(-MAX_FALL);
    localparam logic signed [YS_W-1:0] YMAX_S  = YS_W'(Y_MAX);

    logic [X_W-1:0]        x_q, x_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic signed [V_W-1:0] vy_q, vy_d;
    logic [1:0]            st_q, st_d;
    logic                  face_q, face_d;
    logic                  mov_q, mov_d;
    logic                  armed_q, armed_d;

    logic [X_W:0]          x_ext, x_sub, x_add;
    logic signed [V_W:0]   vy_dec;
    logic signed [YS_W-1:0] y_next;
    logic                  y_move;

    assign x_ext  = {1'b0, x_q};
    assign x_sub  = x_ext - H_EXT;
    assign x_add  = x_ext + H_EXT;
    // Widened by one bit so the gravity step can never wrap the velocity.
    assign vy_dec = {vy_q[V_W-1], vy_q} - GRAV_S;
    // Uses the pre-tick velocity; positive velocity moves the sprite up.
    assign y_next = $signed({2'b00, y_q}) - $signed({{(YS_W-V_W){vy_q[V_W-1]}}, vy_q});

    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        x_d     = x_q;
        face_d  = face_q;
        y_d     = y_q;
        vy_d    = vy_q;
        st_d    = st_q;
        armed_d = armed_q | ~key_jump;
        y_move  = 1'b0;

        // Horizontal: exactly one key moves; a wall on that side blocks it.
        if (key_left && !key_right) begin
            face_d = 1'b1;
            if (!coll[3]) begin
                // x_sub MSB set means the subtraction went below zero.
                if (x_sub[X_W] || x_sub < XMIN_EXT) x_d = XMIN_EXT[X_W-1:0];
                else                                x_d = x_sub[X_W-1:0];
            end
        end else if (key_right && !key_left) begin
            face_d = 1'b0;
            if (!coll[2]) begin
                if (x_add > XMAX_EXT) x_d = XMAX_EXT[X_W-1:0];
                else                  x_d = x_add[X_W-1:0];
            end
        end
        mov_d = (x_d != x_q);

        case (st_q)
            ST_GROUND: begin
                // Velocity is loaded now; y starts moving on the next tick.
                if (key_jump && armed_q) begin
                    vy_d    = V_W'(JUMP_V);
                    st_d    = ST_RISE;
                    armed_d = 1'b0;
                end else begin
                    vy_d = '0;
                    st_d = coll[0] ? ST_GROUND : ST_FALL;
                end
            end
            ST_RISE: begin
                y_move = 1'b1;
                if (coll[1] || !key_jump || vy_dec <= 0) begin
                    vy_d = '0;
                    st_d = ST_FALL;
                end else begin
                    vy_d = vy_dec[V_W-1:0];
                end
            end
            ST_FALL: begin
                if (coll[0]) begin
                    vy_d = '0;
                    st_d = ST_GROUND;
                end else begin
                    y_move = 1'b1;
                    if (vy_dec < NEG_MAX) vy_d = NEG_MAX[V_W-1:0];
                    else                  vy_d = vy_dec[V_W-1:0];
                end
            end
            default: begin
                // Unused encoding: recover to a safe falling state.
                vy_d = '0;
                st_d = ST_FALL;
            end
        endcase

        // Screen clamps override whatever the state machine chose.
        if (y_move) begin
            if (y_next < 0) begin
                y_d  = '0;
                vy_d = '0;
                st_d = ST_FALL;
            end else if (y_next > YMAX_S) begin
                y_d  = YMAX_S[Y_W-1:0];
                vy_d = '0;
                st_d = ST_GROUND;
            end else begin
                y_d = y_next[Y_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            x_q     <= X_W'(X_INIT);
            y_q     <= Y_W'(Y_INIT);
            vy_q    <= '0;
            st_q    <= ST_FALL;
            face_q  <= 1'b0;
            mov_q   <= 1'b0;
            armed_q <= 1'b0;
        end else if (tick) begin
            x_q     <= x_d;
            y_q     <= y_d;
            vy_q    <= vy_d;
            st_q    <= st_d;
            face_q  <= face_d;
            mov_q   <= mov_d;
            armed_q <= armed_d;
        end
    end

    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign vy          = vy_q;
    assign mstate      = st_q;
    assign facing_left = face_q;
    assign moving      = mov_q;

endmodule
